// File: rtl/pll_reconfig_seq.sv
// Sequencer for the pll_cfg Avalon-MM management port: writes one frequency entry,
// applies it, pulses the PLL reset and waits (bounded) for lock.
module pll_reconfig_seq #(
  parameter logic [31:0] N_VALUE      = 32'h00010000,
  parameter logic [31:0] CP_VALUE     = 32'd1,
  parameter logic [31:0] BW_VALUE     = 32'd7,
  parameter int          GAP_CYCLES   = 7,
  parameter int          RST_CYCLES   = 8,
  parameter int          LOCK_TIMEOUT = 1000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] m_val,
  input  logic [31:0] k_val,
  input  logic [31:0] c0_val,
  input  logic        locked,
  input  logic        mgmt_waitrequest,
  output logic        mgmt_write,
  output logic [5:0]  mgmt_address,
  output logic [31:0] mgmt_writedata,
  output logic        pll_reset,
  output logic        busy,
  output logic        done,
  output logic        lock_err
);

  localparam logic [7:0]  GAP_LD   = 8'(GAP_CYCLES);
  localparam logic [7:0]  RST_LD   = 8'(RST_CYCLES);
  localparam logic [23:0] TMO      = 24'(LOCK_TIMEOUT);
  localparam logic [2:0]  LAST_IDX = 3'd7;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    GAP   = 3'd2,
    PRST  = 3'd3,
    WLOCK = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [23:0] timer_q, timer_d;
  logic        pend_q, pend_d;
  logic        err_q, err_d;
  logic [31:0] m_q, k_q, c0_q;
  logic [5:0]  addr_q;
  logic [31:0] data_q;
  logic        load_wr;
  logic        done_c;
  logic        tmo_c;

  function automatic logic [5:0] tbl_addr(input logic [2:0] i);
    case (i)
      3'd0:    tbl_addr = 6'd0;
      3'd1:    tbl_addr = 6'd4;
      3'd2:    tbl_addr = 6'd7;
      3'd3:    tbl_addr = 6'd3;
      3'd4:    tbl_addr = 6'd5;
      3'd5:    tbl_addr = 6'd9;
      3'd6:    tbl_addr = 6'd8;
      default: tbl_addr = 6'd2;
    endcase
  endfunction

  function automatic logic [31:0] tbl_data(input logic [2:0] i, input logic [31:0] m,
                                           input logic [31:0] k, input logic [31:0] c0);
    case (i)
      3'd1:    tbl_data = m;
      3'd2:    tbl_data = k;
      3'd3:    tbl_data = N_VALUE;
      3'd4:    tbl_data = c0;
      3'd5:    tbl_data = CP_VALUE;
      3'd6:    tbl_data = BW_VALUE;
      default: tbl_data = 32'd0;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    timer_d = timer_q;
    pend_d  = pend_q;
    err_d   = err_q;
    load_wr = 1'b0;
    done_c  = 1'b0;
    tmo_c   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start || pend_q) begin
          state_d = WRITE;
          idx_d   = 3'd0;
          pend_d  = 1'b0;
          err_d   = 1'b0;
          load_wr = 1'b1;
        end
      end
      WRITE: begin
        // a restart here is deferred so the current handshake is never cut short
        if (start) pend_d = 1'b1;
        if (!mgmt_waitrequest) begin
          state_d = GAP;
          cnt_d   = GAP_LD;
        end
      end
      GAP: begin
        if (start || (cnt_q <= 8'd1 && pend_q)) begin
          state_d = WRITE;
          idx_d   = 3'd0;
          pend_d  = 1'b0;
          load_wr = 1'b1;
        end else if (cnt_q <= 8'd1) begin
          if (idx_q == LAST_IDX) begin
            state_d = PRST;
            cnt_d   = RST_LD;
          end else begin
            state_d = WRITE;
            idx_d   = idx_q + 3'd1;
            load_wr = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      PRST: begin
        if (start) begin
          state_d = WRITE;
          idx_d   = 3'd0;
          load_wr = 1'b1;
        end else if (cnt_q <= 8'd1) begin
          state_d = WLOCK;
          timer_d = 24'd0;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      WLOCK: begin
        // timer_q == 0 marks the blanking cycle right after pll_reset falls
        if (timer_q != 24'd0 && locked) begin
          done_c = 1'b1;
        end else if (timer_q >= TMO) begin
          done_c = 1'b1;
          tmo_c  = 1'b1;
        end
        if (done_c) begin
          state_d = IDLE;
          pend_d  = start;
          if (tmo_c) err_d = 1'b1;
        end else if (start) begin
          state_d = WRITE;
          idx_d   = 3'd0;
          load_wr = 1'b1;
        end else if (timer_q != 24'hFFFFFF) begin
          timer_d = timer_q + 24'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= 3'd0;
      cnt_q   <= 8'd0;
      timer_q <= 24'd0;
      pend_q  <= 1'b0;
      err_q   <= 1'b0;
      m_q     <= 32'd0;
      k_q     <= 32'd0;
      c0_q    <= 32'd0;
      addr_q  <= 6'd0;
      data_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      timer_q <= timer_d;
      pend_q  <= pend_d;
      err_q   <= err_d;
      if (start) begin
        m_q  <= m_val;
        k_q  <= k_val;
        c0_q <= c0_val;
      end
      if (load_wr) begin
        addr_q <= tbl_addr(idx_d);
        data_q <= tbl_data(idx_d, m_q, k_q, c0_q);
      end
    end
  end

  assign mgmt_write     = (state_q == WRITE);
  assign mgmt_address   = addr_q;
  assign mgmt_writedata = data_q;
  assign pll_reset      = (state_q == PRST);
  assign done           = done_c;
  assign busy           = (state_q != IDLE) && !done_c;
  assign lock_err       = err_q || tmo_c;

endmodule

// File: doc/pll_reconfig_seq.md
Name: pll_reconfig_seq

Overview:
- Drives the Avalon-MM management port of the PLL reconfiguration core (pll_cfg) that sets the SDRAM test clock.
- On a start request it writes one frequency entry (M, K, C0 plus fixed N, charge-pump and bandwidth words) in a fixed register order, applies it, pulses the PLL reset and waits for lock.
- Sits between the frequency-select/control logic and pll_cfg/pll. Its busy output gates the tester reset and the elapsed-time counters.

Parameters:
- N_VALUE, 32'h00010000, data written to the N counter register.
- CP_VALUE, 32'd1, charge-pump register data.
- BW_VALUE, 32'd7, bandwidth register data.
- GAP_CYCLES, 7, idle cycles after each accepted write before the next write is issued (range 1..255).
- RST_CYCLES, 8, number of cycles pll_reset is held high (range 1..255).
- LOCK_TIMEOUT, 1000000, maximum cycles to wait for locked after pll_reset falls (range 1..2^24-1).

Ports:
- clk, in, 1, management clock (CLK_50M domain).
- reset, in, 1, synchronous, active-high.
- start, in, 1, single-cycle request to reconfigure.
- m_val, in, 32, M counter word; sampled when start is accepted.
- k_val, in, 32, fractional K word; sampled when start is accepted.
- c0_val, in, 32, C0 counter word; sampled when start is accepted.
- locked, in, 1, PLL lock, already synchronous to clk.
- mgmt_waitrequest, in, 1, Avalon wait request from pll_cfg.
- mgmt_write, out, 1, Avalon write strobe.
- mgmt_address, out, 6, Avalon register address.
- mgmt_writedata, out, 32, Avalon write data.
- pll_reset, out, 1, PLL reset, active high.
- busy, out, 1, high from start acceptance until done.
- done, out, 1, one-cycle pulse when the sequence ends.
- lock_err, out, 1, sticky flag: the lock wait timed out.

Behaviour:
- Reset: all outputs are 0, the state is IDLE, and all counters and latched values are 0. Reset takes priority over everything in the same cycle. Reset during a pending write drops mgmt_write immediately; pll_cfg is expected to tolerate this.
- Write table, index 0..7, as address/data:
  - 0: 0 / 0 (mode)
  - 1: 4 / m
  - 2: 7 / k
  - 3: 3 / N_VALUE
  - 4: 5 / c0
  - 5: 9 / CP_VALUE
  - 6: 8 / BW_VALUE
  - 7: 2 / 0 (apply)
- States: IDLE, WRITE, GAP, PRST, WLOCK.
- IDLE:
  - start=1 latches m/k/c0, sets busy=1, clears lock_err and sets idx=0.
  - Next state is WRITE; mgmt_write is high on cycle T+1 relative to start at T.
- WRITE:
  - mgmt_write=1 with the table address/data for idx, held stable while mgmt_waitrequest=1.
  - A write is accepted in the cycle where mgmt_write=1 and mgmt_waitrequest=0. The following cycle has mgmt_write=0.
  - After acceptance, go to GAP with the counter loaded to GAP_CYCLES.
- GAP:
  - Count down GAP_CYCLES cycles.
  - At the end, if idx<7: idx++ and go to WRITE. If idx==7: go to PRST.
- PRST: pll_reset=1 for exactly RST_CYCLES cycles, then go to WLOCK with the timer cleared.
- WLOCK:
  - The first cycle after pll_reset falls ignores locked (blanking).
  - From the second cycle, locked=1 gives done=1 for one cycle, busy=0, and a return to IDLE.
  - If the timer reaches LOCK_TIMEOUT without lock: lock_err=1, done=1, busy=0, return to IDLE.
- start while busy (restart):
  - The new m/k/c0 are latched immediately into a pending slot.
  - In WRITE, the current write completes its handshake first. The sequence then goes to GAP and restarts at idx=0 with the pending values.
  - In GAP, PRST or WLOCK, the state returns to WRITE idx=0 on the next cycle and pll_reset drops.
  - busy stays high and no done pulse is generated for the aborted run.
  - Multiple restarts keep only the latest values.
- start coincident with the done cycle is treated as a restart from IDLE on the following cycle.
- mgmt_address and mgmt_writedata hold their last values when mgmt_write=0.
- The timer is 24 bits wide and saturates; it never wraps.

Test Plan:
- Nominal run:
  - Stimulus: waitrequest=0; start with m=32'h167, k=32'h808, c0=32'h20302; locked rises 3 cycles after pll_reset falls.
  - Response: exactly 8 write pulses at addresses 0,4,7,3,5,9,8,2 with data 0,167,808,10000,20302,1,7,0, spaced 8 cycles apart (1 write + 7 gap).
  - Then pll_reset is high for 8 cycles, followed by done for one cycle and busy=0.
- Waitrequest stall: waitrequest=1 for 5 cycles on the idx=2 write → address 7 and data 808 held stable for 6 cycles, exactly one accepted write, all later timing shifted by 5 cycles.
- Lock timeout: LOCK_TIMEOUT=100 and locked held 0 → done and lock_err rise 100 cycles after the blanking cycle. lock_err clears on the next start.
- Restart: start with m=32'h150 during the idx=4 write (waitrequest=1) → that write completes, then the sequence restarts at idx=0 with address 4 carrying 150. Only one done pulse for the whole run.
- Reset mid-PRST: reset=1 for one cycle → pll_reset, busy and mgmt_write are 0 the next cycle. A subsequent start runs a clean full sequence.
- Locked already high: locked=1 throughout → the blanking cycle is ignored, and done fires on the second WLOCK cycle.
